ram2_arbiter: RTL

Two-port round-robin arbiter that shares one single-port 32x32 RAM with a bidirectional data bus between requesters A and B. It sequences every access as a registered enable cycle followed by a mandatory bus-release cycle. It owns the tri-state drive of the shared data bus and returns read data and completion pulses to each requester. It sits directly between the two client blocks and the RAM instance.

---
 rtl/ram2_arbiter.sv | 119 +++++++++++
 1 files changed

// File: rtl/ram2_arbiter.sv
// ram2_arbiter: two-port round-robin arbiter in front of a single-port
// 32x32 RAM that shares one bidirectional data bus.
//
// Every access is an ACCESS cycle (registered ram_ena high) followed by a
// RELEASE cycle (ram_ena low). The RAM only lets go of ram_data while
// ram_ena is low, so the RELEASE cycle is what keeps the arbiter's write
// drive from ever colliding with a RAM read drive.
//
// Handshake: a requester raises req with we/addr/wdata and holds them stable
// until it sees its gnt. Requests are sampled only on edges that leave IDLE
// or RELEASE. gnt_x is high for the single ACCESS cycle of that port's
// access, and done_x pulses in the following RELEASE cycle. For reads,
// rdata_x is valid from that same RELEASE cycle and is held until the next
// read by that port completes.
module ram2_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_a,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] wdata_a,
  input  logic              req_b,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] wdata_b,
  output logic              gnt_a,
  output logic              gnt_b,
  output logic              done_a,
  output logic              done_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b,
  output logic              ram_ena,
  output logic              ram_wena,
  output logic [ADDR_W-1:0] ram_addr,
  inout  wire  [DATA_W-1:0] ram_data,
  output logic [1:0]        fsm_state
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ACCESS  = 2'd1;
  localparam logic [1:0] RELEASE = 2'd2;

  logic [1:0]        state;
  logic              ptr;      // 0 = A has priority, 1 = B has priority
  logic              win;      // port owning the current access: 0 = A, 1 = B
  logic [DATA_W-1:0] wdata_q;

  logic              any_req;
  logic              pick_b;

  // Winner selection: the priority port if it is requesting, else the other.
  always_comb begin
    any_req = req_a | req_b;
    pick_b  = 1'b0;
    if (ptr) pick_b = req_b;
    else     pick_b = ~req_a;
  end

  // FSM, priority pointer and the registered RAM-side control/address/data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= 1'b0;
      win      <= 1'b0;
      ram_ena  <= 1'b0;
      ram_wena <= 1'b0;
      ram_addr <= '0;
      wdata_q  <= '0;
    end else begin
      case (state)
        ACCESS: begin
          ram_ena  <= 1'b0;
          ram_wena <= 1'b0;
          state    <= RELEASE;
        end
        default: begin
          // IDLE and RELEASE arbitrate identically.
          if (any_req) begin
            state    <= ACCESS;
            win      <= pick_b;
            ptr      <= ~pick_b;
            ram_ena  <= 1'b1;
            ram_wena <= pick_b ? we_b    : we_a;
            ram_addr <= pick_b ? addr_b  : addr_a;
            wdata_q  <= pick_b ? wdata_b : wdata_a;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

  // Read data capture on the edge that closes a read ACCESS cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_a <= '0;
      rdata_b <= '0;
    end else if (state == ACCESS && !ram_wena) begin
      if (win) rdata_b <= ram_data;
      else     rdata_a <= ram_data;
    end
  end

  // Grant and completion strobes decode directly from the registered state.
  assign gnt_a  = (state == ACCESS)  && !win;
  assign gnt_b  = (state == ACCESS)  &&  win;
  assign done_a = (state == RELEASE) && !win;
  assign done_b = (state == RELEASE) &&  win;

  // The bus is driven only during a write ACCESS cycle.
  assign ram_data = (ram_ena && ram_wena) ? wdata_q : {DATA_W{1'bz}};

  assign fsm_state = state;

endmodule
